// File: rtl/alu_cu_pkg.sv
// Shared definitions for the alu_cu_datamem execute stage: opcode and
// function-field values, ALU operation codes, branch-select encodings and
// the decoded control bundle.
package alu_cu_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // ADD is code 0 so an all-zero control word is a harmless NOP
   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_NOR  = 5'd5,
      ALU_SLT  = 5'd6,
      ALU_SLTU = 5'd7,
      ALU_SLL  = 5'd8,
      ALU_SRL  = 5'd9,
      ALU_SRA  = 5'd10,
      ALU_LUI  = 5'd11
   } alu_op_e;

   // Next-PC source selected downstream
   typedef enum logic [1:0] {
      BR_PC4 = 2'b00,
      BR_BR  = 2'b01,
      BR_J   = 2'b10,
      BR_JR  = 2'b11
   } br_sel_e;

   // Decoded controls; conditional branches are resolved after the ALU
   typedef struct packed {
      logic    alu_src_a;
      logic    alu_src_b;
      logic    reg_dst;
      logic    reg_write;
      logic    mem_to_reg;
      logic    mem_write;
      logic    pc_to_reg;
      logic    ext_sel;
      logic    ovf_chk;
      logic    is_beq;
      logic    is_bne;
      br_sel_e branch;
      alu_op_e alu_ctrl;
   } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// 32-bit ALU: arithmetic/logic/compare/shift/LUI, zero flag and raw signed
// overflow of ADD/SUB (qualified by the caller).
module alu_core
   import alu_cu_pkg::*;
(
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [4:0]  alu_ctrl,
   output logic [31:0] result,
   output logic        zero,
   output logic        ovf
);

   // Compute the selected operation; shifts move src_b by src_a[4:0]
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      result = '0;
      ovf    = 1'b0;
      case (alu_ctrl)
         ALU_ADD: begin
            result = src_a + src_b;
            ovf    = (src_a[31] == src_b[31]) && (result[31] != src_a[31]);
         end
         ALU_SUB: begin
            result = src_a - src_b;
            ovf    = (src_a[31] != src_b[31]) && (result[31] != src_a[31]);
         end
         ALU_AND:  result = src_a & src_b;
         ALU_OR:   result = src_a | src_b;
         ALU_XOR:  result = src_a ^ src_b;
         ALU_NOR:  result = ~(src_a | src_b);
         ALU_SLT:  result = {31'b0, $signed(src_a) < $signed(src_b)};
         ALU_SLTU: result = {31'b0, src_a < src_b};
         ALU_SLL:  result = src_b << src_a[4:0];
         ALU_SRL:  result = src_b >> src_a[4:0];
         ALU_SRA:  result = $unsigned($signed(src_b) >>> src_a[4:0]);
         ALU_LUI:  result = {src_b[15:0], 16'h0000};
         default:  result = '0;
      endcase
   end

   assign zero = (result == 32'b0);

endmodule

// File: rtl/alu_cu_datamem.sv
// Execute stage of the single-cycle MIPS-subset CPU: control decode, operand
// select, ALU (alu_core) and word-addressed data memory.
// Optional build macro: ALU_OVERFLOW_EN -- flags signed overflow of
// add/sub/addi on ovf and suppresses the register write-back.
module alu_cu_datamem #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic [5:0]  func,
   input  logic [4:0]  shamt,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   input  logic [31:0] ext_imm,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic [31:0] mem_rdata,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        pc_to_reg,
   output logic        ext_sel,
   output logic [1:0]  branch,
   output logic [4:0]  alu_ctrl,
   output logic        ovf
);
   import alu_cu_pkg::*;

   localparam int AW = $clog2(DEPTH);

   ctrl_t       ctrl;
   logic        r_ok;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        core_ovf;
   logic        mem_write;
   logic [AW-1:0] widx;
   logic [31:0] mem [DEPTH];

   // Main + ALU control decode from op/func
   always_comb begin
      ctrl          = '0;
      ctrl.alu_ctrl = ALU_ADD;
      ctrl.branch   = BR_PC4;
      r_ok          = 1'b1;
      case (op)
         OP_RTYPE: begin
            case (func)
               F_ADD:  begin ctrl.alu_ctrl = ALU_ADD; ctrl.ovf_chk = 1'b1; end
               F_ADDU: ctrl.alu_ctrl = ALU_ADD;
               F_SUB:  begin ctrl.alu_ctrl = ALU_SUB; ctrl.ovf_chk = 1'b1; end
               F_SUBU: ctrl.alu_ctrl = ALU_SUB;
               F_AND:  ctrl.alu_ctrl = ALU_AND;
               F_OR:   ctrl.alu_ctrl = ALU_OR;
               F_XOR:  ctrl.alu_ctrl = ALU_XOR;
               F_NOR:  ctrl.alu_ctrl = ALU_NOR;
               F_SLT:  ctrl.alu_ctrl = ALU_SLT;
               F_SLTU: ctrl.alu_ctrl = ALU_SLTU;
               F_SLL:  begin ctrl.alu_ctrl = ALU_SLL; ctrl.alu_src_a = 1'b1; end
               F_SRL:  begin ctrl.alu_ctrl = ALU_SRL; ctrl.alu_src_a = 1'b1; end
               F_SRA:  begin ctrl.alu_ctrl = ALU_SRA; ctrl.alu_src_a = 1'b1; end
               F_SLLV: ctrl.alu_ctrl = ALU_SLL;
               F_SRLV: ctrl.alu_ctrl = ALU_SRL;
               F_SRAV: ctrl.alu_ctrl = ALU_SRA;
               F_JR:   begin r_ok = 1'b0; ctrl.branch = BR_JR; end
               default: r_ok = 1'b0;
            endcase
            ctrl.reg_dst   = r_ok;
            ctrl.reg_write = r_ok;
         end
         OP_ADDI:  begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_sel = 1'b1;
                         ctrl.ovf_chk = 1'b1; end
         OP_ADDIU: begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_sel = 1'b1; end
         OP_SLTI:  begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_sel = 1'b1;
                         ctrl.alu_ctrl = ALU_SLT; end
         OP_SLTIU: begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_sel = 1'b1;
                         ctrl.alu_ctrl = ALU_SLTU; end
         OP_ANDI:  begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_AND; end
         OP_ORI:   begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_OR; end
         OP_XORI:  begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_XOR; end
         OP_LUI:   begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_ctrl = ALU_LUI; end
         OP_LW:    begin ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_sel = 1'b1;
                         ctrl.mem_to_reg = 1'b1; end
         OP_SW:    begin ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b1; ctrl.mem_write = 1'b1; end
         OP_BEQ:   begin ctrl.alu_ctrl = ALU_SUB; ctrl.ext_sel = 1'b1; ctrl.is_beq = 1'b1; end
         OP_BNE:   begin ctrl.alu_ctrl = ALU_SUB; ctrl.ext_sel = 1'b1; ctrl.is_bne = 1'b1; end
         OP_J:     ctrl.branch = BR_J;
         OP_JAL:   begin ctrl.branch = BR_J; ctrl.pc_to_reg = 1'b1; ctrl.reg_write = 1'b1; end
         default:  ;
      endcase
   end

   assign src_a = ctrl.alu_src_a ? {27'b0, shamt} : rd1;
   assign src_b = ctrl.alu_src_b ? ext_imm : rd2;

   alu_core u_alu (
      .src_a    (src_a),
      .src_b    (src_b),
      .alu_ctrl (ctrl.alu_ctrl),
      .result   (alu_result),
      .zero     (zero),
      .ovf      (core_ovf)
   );

   // Resolve conditional branches once the comparison result is known
   always_comb begin
      branch = ctrl.branch;
      if ((ctrl.is_beq && zero) || (ctrl.is_bne && !zero))
         branch = BR_BR;
   end

`ifdef ALU_OVERFLOW_EN
   assign ovf = ctrl.ovf_chk & core_ovf;
`else
   logic unused_ovf;
   assign unused_ovf = ctrl.ovf_chk ^ core_ovf;
   assign ovf        = 1'b0;
`endif

   // State-changing enables are killed immediately while reset is asserted
   assign reg_write  = ctrl.reg_write & rst_n & ~ovf;
   assign mem_write  = ctrl.mem_write & rst_n;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_dst    = ctrl.reg_dst;
   assign pc_to_reg  = ctrl.pc_to_reg;
   assign ext_sel    = ctrl.ext_sel;
   assign alu_ctrl   = ctrl.alu_ctrl;

   // Word index: byte offset dropped, upper address bits wrap
   assign widx = alu_result[AW+1:2];

   // Data memory write port; reset clears every word and aborts a pending store
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking updates for state; the memory is reset explicitly
      // because cleared contents after reset are part of the contract.
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_write) begin
         mem[widx] <= rd2;
      end
   end

   assign mem_rdata = mem[widx];

endmodule

// File: tb/tb_alu_cu_datamem.sv
// Scoreboard bench for alu_cu_datamem: the driver issues one instruction per
// cycle and queues the reference model's expectation; the monitor pops and
// compares at the following falling edge. Honours ALU_OVERFLOW_EN.
module tb_alu_cu_datamem;
   import alu_cu_pkg::*;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [5:0]  op = '0, func = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] rd1 = '0, rd2 = '0, ext_imm = '0;
   logic [31:0] alu_result, mem_rdata;
   logic        zero, mem_to_reg, reg_write, reg_dst, pc_to_reg, ext_sel, ovf;
   logic [1:0]  branch;
   logic [4:0]  alu_ctrl;

   alu_cu_datamem #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func), .shamt(shamt),
      .rd1(rd1), .rd2(rd2), .ext_imm(ext_imm), .alu_result(alu_result),
      .zero(zero), .mem_rdata(mem_rdata), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .reg_dst(reg_dst), .pc_to_reg(pc_to_reg),
      .ext_sel(ext_sel), .branch(branch), .alu_ctrl(alu_ctrl), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        zero;
      logic [31:0] rdata;
      logic        m2r, rw, rdst, p2r, ext, ovf;
      logic [1:0]  br;
      logic [4:0]  ctl;
      bit          wr;
      int          widx;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [DEPTH];
   bit          in_reset = 1'b0;
   int          errors = 0;
   int          checks = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

`ifdef ALU_OVERFLOW_EN
   function automatic bit s_ovf(logic [31:0] a, logic [31:0] b, bit sub);
      longint s;
      s = sub ? (longint'($signed(a)) - longint'($signed(b)))
              : (longint'($signed(a)) + longint'($signed(b)));
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction
`endif

   // Instruction-level reference: what each MIPS instruction should produce
   function automatic exp_t model(logic [5:0] o, logic [5:0] f, logic [4:0] sh,
                                  logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                  bit rst);
      exp_t e;
      bit   chk = 0, sub = 0;
      logic [31:0] opb;
      e = '{name: "", res: a + b, zero: 0, rdata: 0, m2r: 0, rw: 0, rdst: 0,
            p2r: 0, ext: 0, ovf: 0, br: 2'b00, ctl: ALU_ADD, wr: 0, widx: 0};
      opb = b;
      if (o == 6'h00) begin
         e.rw = 1; e.rdst = 1;
         case (f)
            6'h20: begin e.res = a + b; chk = 1; end
            6'h21: e.res = a + b;
            6'h22: begin e.res = a - b; chk = 1; sub = 1; e.ctl = ALU_SUB; end
            6'h23: begin e.res = a - b; e.ctl = ALU_SUB; end
            6'h24: begin e.res = a & b; e.ctl = ALU_AND; end
            6'h25: begin e.res = a | b; e.ctl = ALU_OR; end
            6'h26: begin e.res = a ^ b; e.ctl = ALU_XOR; end
            6'h27: begin e.res = ~(a | b); e.ctl = ALU_NOR; end
            6'h2A: begin e.res = ($signed(a) < $signed(b)) ? 1 : 0; e.ctl = ALU_SLT; end
            6'h2B: begin e.res = (a < b) ? 1 : 0; e.ctl = ALU_SLTU; end
            6'h00: begin e.res = b << sh; e.ctl = ALU_SLL; end
            6'h02: begin e.res = b >> sh; e.ctl = ALU_SRL; end
            6'h03: begin e.res = $signed(b) >>> sh; e.ctl = ALU_SRA; end
            6'h04: begin e.res = b << a[4:0]; e.ctl = ALU_SLL; end
            6'h06: begin e.res = b >> a[4:0]; e.ctl = ALU_SRL; end
            6'h07: begin e.res = $signed(b) >>> a[4:0]; e.ctl = ALU_SRA; end
            6'h08: begin e.rw = 0; e.rdst = 0; e.br = 2'b11; end
            default: begin e.rw = 0; e.rdst = 0; end
         endcase
      end else begin
         case (o)
            6'h08: begin e.res = a + imm; e.rw = 1; e.ext = 1; chk = 1; opb = imm; end
            6'h09: begin e.res = a + imm; e.rw = 1; e.ext = 1; end
            6'h0A: begin e.res = ($signed(a) < $signed(imm)) ? 1 : 0; e.rw = 1; e.ext = 1; e.ctl = ALU_SLT; end
            6'h0B: begin e.res = (a < imm) ? 1 : 0; e.rw = 1; e.ext = 1; e.ctl = ALU_SLTU; end
            6'h0C: begin e.res = a & imm; e.rw = 1; e.ctl = ALU_AND; end
            6'h0D: begin e.res = a | imm; e.rw = 1; e.ctl = ALU_OR; end
            6'h0E: begin e.res = a ^ imm; e.rw = 1; e.ctl = ALU_XOR; end
            6'h0F: begin e.res = imm << 16; e.rw = 1; e.ctl = ALU_LUI; end
            6'h23: begin e.res = a + imm; e.rw = 1; e.ext = 1; e.m2r = 1; end
            6'h2B: begin e.res = a + imm; e.ext = 1; e.wr = 1; end
            6'h04: begin e.res = a - b; e.ext = 1; e.ctl = ALU_SUB; e.br = (a == b) ? 2'b01 : 2'b00; end
            6'h05: begin e.res = a - b; e.ext = 1; e.ctl = ALU_SUB; e.br = (a != b) ? 2'b01 : 2'b00; end
            6'h02: e.br = 2'b10;
            6'h03: begin e.br = 2'b10; e.p2r = 1; e.rw = 1; end
            default: ;
         endcase
      end
`ifdef ALU_OVERFLOW_EN
      if (chk) e.ovf = s_ovf(a, opb, sub);
`else
      if (chk && sub) opb = b;
`endif
      if (e.ovf) e.rw = 0;
      e.zero  = (e.res == 0);
      e.widx  = int'((e.res >> 2) % DEPTH);
      e.rdata = ref_mem[e.widx];
      if (rst) begin e.rw = 0; e.wr = 0; end
      return e;
   endfunction

   task automatic issue(string name, logic [5:0] o, logic [5:0] f, logic [4:0] sh,
                        logic [31:0] a, logic [31:0] b, logic [31:0] imm);
      exp_t e;
      @(posedge clk); #1;
      op = o; func = f; shamt = sh; rd1 = a; rd2 = b; ext_imm = imm;
      e = model(o, f, sh, a, b, imm, in_reset);
      e.name = name;
      sb.push_back(e);
      if (e.wr) ref_mem[e.widx] = b;
   endtask

   // Monitor: compare every queued expectation against the live outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".alu_result"}, alu_result, e.res);
            check({e.name, ".zero"},       zero,       e.zero);
            check({e.name, ".mem_rdata"},  mem_rdata,  e.rdata);
            check({e.name, ".mem_to_reg"}, mem_to_reg, e.m2r);
            check({e.name, ".reg_write"},  reg_write,  e.rw);
            check({e.name, ".reg_dst"},    reg_dst,    e.rdst);
            check({e.name, ".pc_to_reg"},  pc_to_reg,  e.p2r);
            check({e.name, ".ext_sel"},    ext_sel,    e.ext);
            check({e.name, ".branch"},     branch,     e.br);
            check({e.name, ".alu_ctrl"},   alu_ctrl,   e.ctl);
            check({e.name, ".ovf"},        ovf,        e.ovf);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [5:0] rfuncs [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                               6'h08, 6'h3F};
   logic [5:0] iops [16]   = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                               6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h23};

   initial begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      #2 rst_n = 1'b0;
      in_reset = 1'b1;
      issue("rst_add", 6'h00, 6'h20, 0, 32'd5, 32'd7, 0);
      issue("rst_lw",  6'h23, 0, 0, 0, 0, 32'd8);
      @(negedge clk); #1 rst_n = 1'b1; in_reset = 1'b0;

      issue("add",     6'h00, 6'h20, 0, 32'd5, 32'd7, 0);
      issue("beq",     6'h04, 0, 0, 32'h33, 32'h33, 0);
      issue("bne",     6'h05, 0, 0, 32'h33, 32'h33, 0);
      issue("bne_ne",  6'h05, 0, 0, 32'h33, 32'h34, 0);
      issue("sw",      6'h2B, 0, 0, 0, 32'hDEADBEEF, 32'd8);
      issue("lw",      6'h23, 0, 0, 0, 0, 32'd8);
      issue("sw_wrap", 6'h2B, 0, 0, 32'h100, 32'h0BADF00D, 32'd4);
      issue("lw_wrap", 6'h23, 0, 0, 0, 0, 32'd5);
      issue("slt",     6'h00, 6'h2A, 0, 32'hFFFFFFFF, 32'd1, 0);
      issue("sltu",    6'h00, 6'h2B, 0, 32'hFFFFFFFF, 32'd1, 0);
      issue("sra",     6'h00, 6'h03, 5'd4, 32'h1234, 32'h80000000, 0);
      issue("lui",     6'h0F, 0, 0, 32'h55, 0, 32'h1234);
      issue("jal",     6'h03, 0, 0, 32'd1, 32'd2, 0);
      issue("jr",      6'h00, 6'h08, 0, 32'h400, 32'd0, 0);
      issue("bad_op",  6'h3F, 0, 0, 32'd9, 32'd1, 32'd3);
      issue("bad_fn",  6'h00, 6'h3F, 0, 32'd9, 32'd1, 32'd3);
      issue("addiu_w", 6'h09, 0, 0, 32'h7FFFFFFF, 0, 32'd1);
      issue("addi_ov", 6'h08, 0, 0, 32'h7FFFFFFF, 0, 32'd1);
      issue("sub_ov",  6'h00, 6'h22, 0, 32'h80000000, 32'd1, 0);

      // Reset lands before the store's clock edge: write aborted, memory cleared
      issue("sw_rst",  6'h2B, 0, 0, 0, 32'hCAFEF00D, 32'd8);
      @(negedge clk); #1 rst_n = 1'b0; in_reset = 1'b1;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      issue("rst_add2", 6'h00, 6'h20, 0, 32'd5, 32'd7, 0);
      issue("rst_lw2",  6'h23, 0, 0, 0, 0, 32'd8);
      @(negedge clk); #1 rst_n = 1'b1; in_reset = 1'b0;
      issue("post_lw",  6'h23, 0, 0, 0, 0, 32'd8);

      for (int n = 0; n < 300; n++) begin
         logic [5:0]  o, f;
         logic [31:0] a, b, imm;
         logic [15:0] i16;
         i16 = 16'($urandom);
         imm = {{16{i16[15]}}, i16};
         a   = $urandom;
         b   = $urandom;
         if ($urandom_range(0, 99) < 45) begin
            o = 6'h00;
            f = rfuncs[$urandom_range(0, 17)];
         end else begin
            o = iops[$urandom_range(0, 15)];
            f = 6'($urandom);
         end
         if (o == 6'h23 || o == 6'h2B) begin
            a   = $urandom_range(0, 511);
            imm = $urandom_range(0, 31) * 4;
         end
         if ($urandom_range(0, 3) == 0) b = a;
         issue($sformatf("rnd%0d", n), o, f, 5'($urandom), a, b, imm);
      end

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
